// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multi-cycle MIPS datapath with a memory ready handshake.
// Optional performance counters are enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic             mem_to_reg_o,
  output logic             reg_dst_o,
  output logic             ext_zero_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic             illegal_op_o,
  output logic [3:0]       state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
`endif
);

  typedef enum logic [3:0] {
    StReset  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StRtExe  = 4'd7,
    StRtWb   = 4'd8,
    StIExe   = 4'd9,
    StIWb    = 4'd10,
    StBranch = 4'd11,
    StJump   = 4'd12,
    StTrap   = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluAnd   = 3'b010;
  localparam logic [2:0] AluOr    = 3'b011;
  localparam logic [2:0] AluXor   = 3'b100;
  localparam logic [2:0] AluSlt   = 3'b101;
  localparam logic [2:0] AluLui   = 3'b110;
  localparam logic [2:0] AluFunct = 3'b111;

  state_e     state_q, state_d;

  logic       i_or_d_q, i_or_d_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_to_reg_q, mem_to_reg_d;
  logic       reg_dst_q, reg_dst_d;
  logic       ext_zero_q, ext_zero_d;
  logic       alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [1:0] pc_source_q, pc_source_d;
  logic       illegal_op_q, illegal_op_d;
  // Unconditional PC load (JUMP, TRAP); FETCH and BRANCH loads depend on live inputs.
  logic       pc_jump_q, pc_jump_d;

  logic [2:0] imm_alu_op;
  logic       imm_ext_zero;
  logic       branch_taken;

  always_comb begin
    imm_alu_op   = AluAdd;
    imm_ext_zero = 1'b0;
    case (opcode_i)
      OpAddi: imm_alu_op = AluAdd;
      OpSlti: imm_alu_op = AluSlt;
      OpAndi: begin
        imm_alu_op   = AluAnd;
        imm_ext_zero = 1'b1;
      end
      OpOri: begin
        imm_alu_op   = AluOr;
        imm_ext_zero = 1'b1;
      end
      OpXori: begin
        imm_alu_op   = AluXor;
        imm_ext_zero = 1'b1;
      end
      OpLui:   imm_alu_op = AluLui;
      default: imm_alu_op = AluAdd;
    endcase
  end

  assign branch_taken = ((opcode_i == OpBeq) && zero_i) || ((opcode_i == OpBne) && !zero_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset:  state_d = StFetch;
      StFetch:  if (mem_ready_i) state_d = StDecode;
      StDecode: begin
        case (opcode_i)
          OpRtype:     state_d = StRtExe;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:         state_d = StJump;
          OpAddi, OpSlti, OpAndi, OpOri, OpXori, OpLui: state_d = StIExe;
          default:     state_d = StTrap;
        endcase
      end
      StMemAdr: state_d = (opcode_i == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready_i) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_ready_i) state_d = StFetch;
      StRtExe:  state_d = StRtWb;
      StRtWb:   state_d = StFetch;
      StIExe:   state_d = StIWb;
      StIWb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StTrap:   state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    i_or_d_d     = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_dst_d    = 1'b0;
    ext_zero_d   = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = 2'b00;
    alu_op_d     = AluAdd;
    pc_source_d  = 2'b00;
    illegal_op_d = 1'b0;
    pc_jump_d    = 1'b0;
    case (state_d)
      StFetch: begin
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b01;
      end
      StDecode: alu_src_b_d = 2'b11;
      StMemAdr: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      StMemRd: begin
        mem_read_d = 1'b1;
        i_or_d_d   = 1'b1;
      end
      StMemWb: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      StMemWr: begin
        mem_write_d = 1'b1;
        i_or_d_d    = 1'b1;
      end
      StRtExe: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = AluFunct;
      end
      StRtWb: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      StIExe: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        alu_op_d    = imm_alu_op;
        ext_zero_d  = imm_ext_zero;
      end
      StIWb: begin
        reg_write_d = 1'b1;
        ext_zero_d  = imm_ext_zero;
      end
      StBranch: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = AluSub;
        pc_source_d = 2'b01;
      end
      StJump: begin
        pc_jump_d   = 1'b1;
        pc_source_d = 2'b10;
      end
      StTrap: begin
        pc_jump_d    = 1'b1;
        pc_source_d  = 2'b11;
        illegal_op_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StReset;
      i_or_d_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_dst_q    <= 1'b0;
      ext_zero_q   <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= 2'b00;
      alu_op_q     <= AluAdd;
      pc_source_q  <= 2'b00;
      illegal_op_q <= 1'b0;
      pc_jump_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_or_d_q     <= i_or_d_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_dst_q    <= reg_dst_d;
      ext_zero_q   <= ext_zero_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_op_q     <= alu_op_d;
      pc_source_q  <= pc_source_d;
      illegal_op_q <= illegal_op_d;
      pc_jump_q    <= pc_jump_d;
    end
  end

  assign ir_write_o   = (state_q == StFetch) && mem_ready_i;
  assign pc_write_o   = pc_jump_q || ((state_q == StFetch) && mem_ready_i) ||
                        ((state_q == StBranch) && branch_taken);
  assign i_or_d_o     = i_or_d_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign reg_write_o  = reg_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign reg_dst_o    = reg_dst_q;
  assign ext_zero_o   = ext_zero_q;
  assign alu_src_a_o  = alu_src_a_q;
  assign alu_src_b_o  = alu_src_b_q;
  assign alu_op_o     = alu_op_q;
  assign pc_source_o  = pc_source_q;
  assign illegal_op_o = illegal_op_q;
  assign state_o      = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_q, instr_cnt_q;
  logic             instr_done;

  // Trap completions are deliberately excluded from the retired-instruction count.
  assign instr_done = (state_d == StFetch) &&
                      (state_q inside {StMemWb, StMemWr, StRtWb, StIWb, StBranch, StJump});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (state_q != StReset) cyc_cnt_q <= cyc_cnt_q + 1'b1;
      if (instr_done) instr_cnt_q <= instr_cnt_q + 1'b1;
    end
  end

  assign cyc_cnt_o   = cyc_cnt_q;
  assign instr_cnt_o = instr_cnt_q;
`endif

endmodule
